// File: rtl/alu_pkg.sv
// Shared ALU types: widths, flag bit positions, buffered result entry and
// the output-stage buffer state encoding.
package alu_pkg;

   localparam int unsigned ALU_W     = 4;
   localparam int unsigned ALU_TAG_W = 3;
   localparam int unsigned FLAG_W    = 4;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef struct packed {
      logic [ALU_W-1:0]     y;
      logic [FLAG_W-1:0]    flags;
      logic [ALU_TAG_W-1:0] tag;
   } alu_entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V flag derivation for one ALU result.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int unsigned W = ALU_W
) (
   input  logic [W-1:0]      y_i,
   input  logic              cout_i,
   input  logic              ovf_i,
   output logic [FLAG_W-1:0] flags_o
);

   always_comb begin
      flags_o         = '0;
      flags_o[FLAG_N] = y_i[W-1];
      flags_o[FLAG_Z] = (y_i == '0);
      flags_o[FLAG_C] = cout_i;
      flags_o[FLAG_V] = ovf_i;
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag capture, sequence tagging and a 2-entry
// skid buffer. Optional sticky C/V flags enabled by ALU_FLAG_STICKY_EN.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned W     = ALU_W,
   parameter int unsigned TAG_W = ALU_TAG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_y,
   input  logic              in_cout,
   input  logic              in_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_y,
   output logic [FLAG_W-1:0] out_flags,
   output logic [TAG_W-1:0]  out_tag,
   input  logic              clr_sticky,
   output logic [1:0]        sticky_cv
);

   logic [FLAG_W-1:0] in_flags;
   alu_entry_t        new_entry;
   alu_entry_t        out_q;
   alu_entry_t        skid_q;
   buf_state_t        state_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [TAG_W-1:0]  tag_q;
   logic              accept;
   logic              pop;

   alu_flag_gen #(.W(W)) u_flag_gen (
      .y_i     (in_y),
      .cout_i  (in_cout),
      .ovf_i   (in_ovf),
      .flags_o (in_flags)
   );

   assign accept = in_valid & in_ready_q;
   assign pop    = out_valid_q & out_ready;

   always_comb begin
      new_entry       = '0;
      new_entry.y     = ALU_W'(in_y);
      new_entry.flags = in_flags;
      new_entry.tag   = ALU_TAG_W'(tag_q);
   end

   // Skid buffer: out_q is the visible head, skid_q catches the second result
   // so in_ready can stay purely state-derived.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  out_q       <= new_entry;
                  out_valid_q <= 1'b1;
                  state_q     <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  out_q <= new_entry;
               end else if (accept) begin
                  skid_q     <= new_entry;
                  in_ready_q <= 1'b0;
                  state_q    <= FULL;
               end else if (pop) begin
                  out_valid_q <= 1'b0;
                  state_q     <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  out_q      <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Sequence tag wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= '0;
      end else if (accept) begin
         tag_q <= tag_q + TAG_W'(1);
      end
   end

`ifdef ALU_FLAG_STICKY_EN
   logic [1:0] sticky_q;
   logic [1:0] acc_cv;

   assign acc_cv = accept ? {in_flags[FLAG_C], in_flags[FLAG_V]} : 2'b00;

   // Clear wins but still keeps the C/V of a same-cycle accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 2'b00;
      end else if (clr_sticky) begin
         sticky_q <= acc_cv;
      end else begin
         sticky_q <= sticky_q | acc_cv;
      end
   end

   assign sticky_cv = sticky_q;
`else
   logic unused_clr_sticky;

   assign unused_clr_sticky = clr_sticky;
   assign sticky_cv         = 2'b00;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_y     = W'(out_q.y);
   assign out_flags = out_q.flags;
   assign out_tag   = TAG_W'(out_q.tag);

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic against
// a queue-based reference model of the 2-deep result buffer.
module tb_alu_result_stage;

   localparam int unsigned W     = 4;
   localparam int unsigned TAG_W = 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_y;
   logic             in_cout;
   logic             in_ovf;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_y;
   logic [3:0]       out_flags;
   logic [TAG_W-1:0] out_tag;
   logic             clr_sticky;
   logic [1:0]       sticky_cv;

   alu_result_stage #(.W(W), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_y       (in_y),
      .in_cout    (in_cout),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_flags  (out_flags),
      .out_tag    (out_tag),
      .clr_sticky (clr_sticky),
      .sticky_cv  (sticky_cv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int y;
      int flags;
      int tag;
   } exp_t;

   exp_t q[$];
   int   tag_m;
   int   sticky_m;
   int   n_checks;
   int   n_pass;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   function automatic int flags_of(input int y, input int c, input int v);
      return ((y >= 8) ? 8 : 0) + ((y == 0) ? 4 : 0) + 2 * c + v;
   endfunction

   task automatic check_outputs();
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
         check("out_y", out_y, q[0].y);
         check("out_flags", out_flags, q[0].flags);
         check("out_tag", out_tag, q[0].tag);
      end
      check("sticky_cv", sticky_cv, sticky_m);
   endtask

   // Called at a negedge: drive, clock once, advance model, check at next negedge.
   task automatic cycle(input bit v, input int y, input bit c, input bit o,
                        input bit rdy, input bit clr);
      bit acc;
      bit pop;
      in_valid   = v;
      in_y       = W'(y);
      in_cout    = c;
      in_ovf     = o;
      out_ready  = rdy;
      clr_sticky = clr;
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && rdy;
      @(posedge clk);
`ifdef ALU_FLAG_STICKY_EN
      if (clr) sticky_m = acc ? (2 * c + o) : 0;
      else if (acc) sticky_m = sticky_m | (2 * c + o);
`endif
      if (pop) void'(q.pop_front());
      if (acc) begin
         q.push_back('{y: y, flags: flags_of(y, c, o), tag: tag_m});
         tag_m = (tag_m + 1) % (1 << TAG_W);
      end
      @(negedge clk);
      check_outputs();
   endtask

   // Called at a negedge: asynchronous reset pulse, checked while asserted.
   task automatic do_reset();
      in_valid   = 1'b0;
      clr_sticky = 1'b0;
      rst_n      = 1'b0;
      #1;
      check("rst out_valid", out_valid, 0);
      check("rst in_ready", in_ready, 1);
      check("rst out_y", out_y, 0);
      check("rst out_flags", out_flags, 0);
      check("rst out_tag", out_tag, 0);
      check("rst sticky_cv", sticky_cv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      tag_m    = 0;
      sticky_m = 0;
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_y       = '0;
      in_cout    = 1'b0;
      in_ovf     = 1'b0;
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
      tag_m      = 0;
      sticky_m   = 0;
      repeat (2) @(negedge clk);
      do_reset();

      // Single MUL 7x3 result, then zero and negative results.
      cycle(1, 5, 1, 1, 1, 0);
      check("first y", out_y, 5);
      check("first flags", out_flags, 4'b0011);
      check("first tag", out_tag, 0);
      cycle(1, 0, 0, 0, 1, 0);
      check("zero flags", out_flags, 4'b0100);
      cycle(1, 10, 0, 0, 1, 0);
      check("neg flags", out_flags, 4'b1000);
      cycle(0, 0, 0, 0, 1, 0);
      check("drained", out_valid, 0);

      // Backpressure: third push is refused, output holds while stalled.
      do_reset();
      cycle(1, 1, 0, 0, 0, 0);
      cycle(1, 2, 0, 0, 0, 0);
      check("full in_ready", in_ready, 0);
      cycle(1, 3, 0, 0, 0, 0);
      check("stall y", out_y, 1);
      check("stall tag", out_tag, 0);
      cycle(0, 0, 0, 0, 1, 0);
      check("release in_ready", in_ready, 1);
      check("second y", out_y, 2);
      check("second tag", out_tag, 1);
      cycle(0, 0, 0, 0, 1, 0);

      // Tag wrap over nine back-to-back accepts.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(1, i, 0, 0, 1, 0);
         check("wrap tag", out_tag, i % 8);
      end
      cycle(0, 0, 0, 0, 1, 0);

      // Sticky C/V accumulation and clear-with-accept.
      do_reset();
      cycle(1, 1, 1, 0, 1, 0);
      cycle(1, 1, 0, 0, 1, 0);
`ifdef ALU_FLAG_STICKY_EN
      check("sticky acc", sticky_cv, 2'b10);
`else
      check("sticky off", sticky_cv, 2'b00);
`endif
      cycle(1, 1, 0, 1, 1, 1);
`ifdef ALU_FLAG_STICKY_EN
      check("sticky clr", sticky_cv, 2'b01);
`endif
      cycle(0, 0, 0, 0, 1, 0);

      // Reset while FULL discards entries and restarts the tag.
      cycle(1, 4, 0, 0, 0, 0);
      cycle(1, 6, 0, 0, 0, 0);
      check("prefull in_ready", in_ready, 0);
      do_reset();
      cycle(1, 7, 0, 0, 1, 0);
      check("post-reset tag", out_tag, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
